nonce_select: RTL and testbench

Downstream stage of the bitcoin hash core. Once the hash core has written one 32-bit hash word per nonce into shared memory, this block reads the NUM_NONCES words back. It finds the smallest hash and its nonce index, and compares that hash against a difficulty target. It then writes a two-word result record to memory and holds the winner on output ports for the top-level controller.

---
 rtl/nonce_select.sv | 138 +++++++++++++
 tb/tb_nonce_select.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_select.sv
// Scans NUM_NONCES hash words from shared memory, keeps the smallest one and its
// index, compares it against the latched target and writes a two-word result record.
module nonce_select #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [7:0]  best_nonce,
    output logic [31:0] best_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int CW = $clog2(NUM_NONCES + 1);
    localparam logic [CW-1:0] CNT_END  = CW'(NUM_NONCES);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_NONCES - 1);

    typedef enum logic [2:0] {IDLE, SCAN, WR0, WR1, FIN} state_t;

    state_t        state, state_d;
    logic [31:0]   target_q, target_d;
    logic [CW-1:0] issue_cnt, issue_cnt_d;
    logic [CW-1:0] cap_cnt, cap_cnt_d;
    // vld_pipe[0]: address issued this edge; vld_pipe[1]: read data arrives next edge
    logic [1:0]    vld_pipe, vld_pipe_d;
    logic          done_d, found_d, mem_we_d;
    logic [7:0]    best_nonce_d;
    logic [31:0]   best_hash_d, mem_write_data_d;
    logic [15:0]   mem_addr_d;

    assign mem_clk = clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            target_q       <= '0;
            issue_cnt      <= '0;
            cap_cnt        <= '0;
            vld_pipe       <= '0;
            done           <= 1'b0;
            found          <= 1'b0;
            best_nonce     <= '0;
            best_hash      <= 32'hFFFF_FFFF;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            state          <= state_d;
            target_q       <= target_d;
            issue_cnt      <= issue_cnt_d;
            cap_cnt        <= cap_cnt_d;
            vld_pipe       <= vld_pipe_d;
            done           <= done_d;
            found          <= found_d;
            best_nonce     <= best_nonce_d;
            best_hash      <= best_hash_d;
            mem_we         <= mem_we_d;
            mem_addr       <= mem_addr_d;
            mem_write_data <= mem_write_data_d;
        end
    end

    always_comb begin
        state_d          = state;
        target_d         = target_q;
        issue_cnt_d      = issue_cnt;
        cap_cnt_d        = cap_cnt;
        vld_pipe_d       = vld_pipe;
        done_d           = 1'b0;
        found_d          = found;
        best_nonce_d     = best_nonce;
        best_hash_d      = best_hash;
        mem_we_d         = 1'b0;
        mem_addr_d       = mem_addr;
        mem_write_data_d = mem_write_data;

        case (state)
            IDLE: begin
                if (start) begin
                    target_d     = target;
                    mem_addr_d   = hash_addr;
                    issue_cnt_d  = CW'(1);
                    cap_cnt_d    = '0;
                    best_hash_d  = 32'hFFFF_FFFF;
                    best_nonce_d = '0;
                    vld_pipe_d   = 2'b01;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                vld_pipe_d = {vld_pipe[0], 1'b0};
                if (issue_cnt < CNT_END) begin
                    mem_addr_d    = hash_addr + 16'(issue_cnt);
                    issue_cnt_d   = issue_cnt + CW'(1);
                    vld_pipe_d[0] = 1'b1;
                end
                if (vld_pipe[1]) begin
                    // strict compare so ties keep the earlier nonce
                    if (mem_read_data < best_hash) begin
                        best_hash_d  = mem_read_data;
                        best_nonce_d = 8'(cap_cnt);
                    end
                    cap_cnt_d = cap_cnt + CW'(1);
                    if (cap_cnt == CNT_LAST) state_d = WR0;
                end
            end
            WR0: begin
                vld_pipe_d       = '0;
                found_d          = best_hash < target_q;
                mem_we_d         = 1'b1;
                mem_addr_d       = result_addr;
                mem_write_data_d = {found_d, 23'b0, best_nonce};
                state_d          = WR1;
            end
            WR1: begin
                mem_we_d         = 1'b1;
                mem_addr_d       = result_addr + 16'd1;
                mem_write_data_d = best_hash;
                state_d          = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nonce_select.sv
// Randomised scoreboard bench for nonce_select with a behavioural RAM and a
// min-search reference model.
module tb_nonce_select;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] hash_addr = '0;
    logic [15:0] result_addr = '0;
    logic [31:0] target = '0;
    logic        done, found, mem_clk, mem_we;
    logic [7:0]  best_nonce;
    logic [31:0] best_hash, mem_write_data;
    logic [15:0] mem_addr;
    logic [31:0] rd_q;

    logic [31:0] mem [0:65535];

    typedef struct {
        logic [31:0] hash;
        logic [7:0]  nonce;
        logic        hit;
        logic [15:0] raddr;
        int          e0;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    nonce_select #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .hash_addr(hash_addr), .result_addr(result_addr), .target(target),
        .done(done), .found(found), .best_nonce(best_nonce), .best_hash(best_hash),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(rd_q)
    );

    always #5 clk = ~clk;

    always @(posedge mem_clk) begin
        if (mem_we) mem[mem_addr] <= mem_write_data;
        rd_q <= mem[mem_addr];
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: smallest word over the region, earliest index on ties.
    function automatic exp_t model(input logic [15:0] h, input logic [15:0] r, input logic [31:0] t);
        exp_t e;
        e.hash  = 32'hFFFF_FFFF;
        e.nonce = 8'd0;
        for (int i = 0; i < N; i++) begin
            if (mem[16'(h + i)] < e.hash) begin
                e.hash  = mem[16'(h + i)];
                e.nonce = 8'(i);
            end
        end
        e.hit   = e.hash < t;
        e.raddr = r;
        e.e0    = 0;
        return e;
    endfunction

    task automatic load(input logic [15:0] h, input int i, input logic [31:0] v);
        mem[16'(h + i)] <= v;
    endtask

    task automatic issue(input logic [15:0] h, input logic [15:0] r, input logic [31:0] t,
                         input bit push, input bit hold, output int e0);
        exp_t e;
        @(negedge clk);
        e = model(h, r, t);
        e.e0 = cyc + 1;
        e0 = e.e0;
        hash_addr = h;
        result_addr = r;
        target = t;
        start = 1'b1;
        if (push) sb.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d results still pending after %0d cycles", sb.size(), budget);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: checks every done pulse against the oldest scoreboard entry.
    initial begin
        int          we_cnt = 0;
        logic [15:0] wa[2];
        exp_t        e;
        wa[0] = '0;
        wa[1] = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                we_cnt = 0;
            end else begin
                if (mem_we) begin
                    if (we_cnt < 2) wa[we_cnt] = mem_addr;
                    we_cnt++;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("latency", 32'(cyc - e.e0), 32'(N + 4));
                        chk("best_hash", best_hash, e.hash);
                        chk("best_nonce", {24'b0, best_nonce}, {24'b0, e.nonce});
                        chk("found", {31'b0, found}, {31'b0, e.hit});
                        chk("record0", mem[e.raddr], {e.hit, 23'b0, e.nonce});
                        chk("record1", mem[16'(e.raddr + 16'd1)], e.hash);
                        chk("write_cycles", 32'(we_cnt), 32'd2);
                        chk("write_addr0", {16'b0, wa[0]}, {16'b0, e.raddr});
                        chk("write_addr1", {16'b0, wa[1]}, {16'b0, 16'(e.raddr + 16'd1)});
                    end
                    we_cnt = 0;
                end
            end
        end
    end

    initial begin
        int          e0;
        logic [15:0] h, r;
        logic [31:0] t;

        for (int a = 0; a < 65536; a++) mem[a] = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_found", {31'b0, found}, 32'd0);
        chk("rst_nonce", {24'b0, best_nonce}, 32'd0);
        chk("rst_hash", best_hash, 32'hFFFF_FFFF);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", {16'b0, mem_addr}, 32'd0);
        reset_n = 1'b1;

        // distinct hashes, one clear winner below target
        for (int i = 0; i < N; i++) load(16'h1000, i, 32'(100 + 16 * i));
        load(16'h1000, 9, 32'd5);
        issue(16'h1000, 16'h2000, 32'd10, 1'b1, 1'b0, e0);
        wait_idle(100);
        chk("t1_rec0", mem[16'h2000], 32'h8000_0009);
        chk("t1_rec1", mem[16'h2001], 32'h0000_0005);

        // tie on the minimum, equal to target -> no hit
        for (int i = 0; i < N; i++) load(16'h1100, i, 32'(200 + i));
        load(16'h1100, 3, 32'h40);
        load(16'h1100, 12, 32'h40);
        issue(16'h1100, 16'h2100, 32'h40, 1'b1, 1'b0, e0);
        wait_idle(100);
        chk("t2_rec0", mem[16'h2100], 32'h0000_0003);

        // all ones
        for (int i = 0; i < N; i++) load(16'h3000, i, 32'hFFFF_FFFF);
        issue(16'h3000, 16'h3100, 32'hFFFF_FFFF, 1'b1, 1'b0, e0);
        wait_idle(100);
        chk("t3_rec0", mem[16'h3100], 32'h0000_0000);

        // address wrap
        for (int i = 0; i < N; i++) load(16'hFFF8, i, $urandom_range(1000, 5000));
        load(16'hFFF8, 11, 32'd7);
        issue(16'hFFF8, 16'h0100, 32'd8, 1'b1, 1'b0, e0);
        wait_idle(100);

        // randomised scans, small value ranges to provoke ties
        for (int k = 0; k < 8; k++) begin
            h = 16'($urandom);
            r = h + 16'h0200;
            for (int i = 0; i < N; i++)
                load(h, i, ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 7));
            t = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 8);
            issue(h, r, t, 1'b1, 1'b0, e0);
            wait_idle(100);
        end

        // reset in the middle of a scan
        for (int i = 0; i < N; i++) load(16'h4000, i, 32'(i + 1));
        mem[16'h4100] <= 32'hDEAD_BEEF;
        mem[16'h4101] <= 32'hCAFE_F00D;
        issue(16'h4000, 16'h4100, 32'hFFFF_FFFF, 1'b0, 1'b0, e0);
        while (cyc < e0 + 8) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_found", {31'b0, found}, 32'd0);
        chk("mid_rst_nonce", {24'b0, best_nonce}, 32'd0);
        chk("mid_rst_hash", best_hash, 32'hFFFF_FFFF);
        chk("mid_rst_we", {31'b0, mem_we}, 32'd0);
        chk("mid_rst_addr", {16'b0, mem_addr}, 32'd0);
        chk("mid_rst_wdata", mem_write_data, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_rst_rec0", mem[16'h4100], 32'hDEAD_BEEF);
        chk("mid_rst_rec1", mem[16'h4101], 32'hCAFE_F00D);
        issue(16'h4000, 16'h4100, 32'd2, 1'b1, 1'b0, e0);
        wait_idle(100);

        // start pulse while busy must be ignored
        issue(16'h1000, 16'h2000, 32'd3, 1'b1, 1'b0, e0);
        while (cyc < e0 + 4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(100);

        // start held high: second scan starts on the edge after done
        for (int i = 0; i < N; i++) load(16'h5000, i, $urandom_range(0, 63));
        issue(16'h5000, 16'h5100, 32'd20, 1'b1, 1'b1, e0);
        begin
            exp_t e2;
            e2 = model(16'h5000, 16'h5100, 32'd20);
            e2.e0 = e0 + N + 5;
            sb.push_back(e2);
        end
        while (cyc < e0 + N + 5) @(negedge clk);
        start = 1'b0;
        wait_idle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
